// File: rtl/function_arbiter.sv
// function_arbiter: captures rising edges on N request lines into a sticky
// pending set and grants one function at a time as a one-hot `sets` vector.
// Handshake: a channel requests by raising reqs[i] (edge, not level); the
// grant is `sets` one-hot with a one-cycle `fin` on its first cycle; the
// granted function releases it by holding `done` high at a BUSY clock edge,
// or the watchdog releases it after TIMEOUT BUSY cycles (pulsing `timeout`).
module function_arbiter #(
  parameter int N       = 2,
  parameter int RR      = 0,
  parameter int TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] reqs,
  input  logic         done,
  output logic [N-1:0] sets,
  output logic         fin,
  output logic         busy,
  output logic [N-1:0] pending,
  output logic         timeout,
  output logic         dbg_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t          state, state_n;
  logic [N-1:0]    req_q;
  logic [N-1:0]    rise;
  logic [N-1:0]    clr;
  logic [N-1:0]    win_oh;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_n;
  logic [CW-1:0]   cnt;
  logic            found;
  logic            grant;
  logic            expire;
  logic            wd_hit;
  int              base;
  int              idx;

  assign rise      = reqs & ~req_q;
  assign clr       = grant ? win_oh : '0;
  assign busy      = (state == S_BUSY);
  assign dbg_state = state;
  // Count holds BUSY cycles already completed; this edge ends cycle cnt+1.
  assign wd_hit    = (TIMEOUT > 0) && (cnt == WD_LAST);
  assign ptr_n     = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);

  // Winner search: start at ptr in round-robin mode, at 0 in fixed priority.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    base    = (RR != 0) ? int'(ptr) : 0;
    for (int off = 0; off < N; off++) begin
      idx = base + off;
      if (idx >= N) idx = idx - N;
      if (!found && pending[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = PW'(idx);
      end
    end
  end

  // Next-state logic; done takes precedence over watchdog expiry.
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    expire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_n = S_BUSY;
          grant   = 1'b1;
        end
      end
      S_BUSY: begin
        if (done) begin
          state_n = S_IDLE;
        end else if (wd_hit) begin
          state_n = S_IDLE;
          expire  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, grant, pending set, pointer and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      req_q   <= '0;
      pending <= '0;
      sets    <= '0;
      fin     <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      req_q   <= reqs;
      // A rise on the bit being granted keeps it pending.
      pending <= (pending & ~clr) | rise;
      fin     <= grant;
      timeout <= expire;
      if (grant) begin
        sets <= win_oh;
        ptr  <= ptr_n;
        cnt  <= '0;
      end else if (state == S_BUSY && state_n == S_IDLE) begin
        sets <= '0;
      end else if (state == S_BUSY) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
